// File: rtl/belt_warn_pkg.sv
// Shared types and default timing for the seat-belt warning sequencer.
package belt_warn_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        GRACE     = 3'd1,
        BEEP_ON   = 3'd2,
        BEEP_OFF  = 3'd3,
        LAMP_ONLY = 3'd4
    } belt_state_e;

    localparam int unsigned DEF_DEBOUNCE_CYC = 16;
    localparam int unsigned DEF_DELAY_CYC    = 100;
    localparam int unsigned DEF_BEEP_ON_CYC  = 50;
    localparam int unsigned DEF_BEEP_OFF_CYC = 50;
    localparam int unsigned DEF_MAX_BEEPS    = 6;

    // Largest of three cycle counts; sizes the shared phase timer.
    function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/belt_debounce.sv
// Two-flop synchronizer followed by a stability counter for one raw switch.
module belt_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Level only follows sync2 after DEBOUNCE_CYC consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != level) begin
                if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/belt_warning_ctrl.sv
// Seat-belt warning sequencer: grace delay, limited chime, persistent lamp.
// Optional passenger-belt check enabled by defining BELT_PASSENGER_CHECK_EN.
module belt_warning_ctrl
    import belt_warn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned DELAY_CYC    = DEF_DELAY_CYC,
    parameter int unsigned BEEP_ON_CYC  = DEF_BEEP_ON_CYC,
    parameter int unsigned BEEP_OFF_CYC = DEF_BEEP_OFF_CYC,
    parameter int unsigned MAX_BEEPS    = DEF_MAX_BEEPS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               d_in,
    input  logic               k_in,
    input  logic               s_in,
    input  logic               b_in,
`ifdef BELT_PASSENGER_CHECK_EN
    input  logic               pb_in,
`endif
    output logic               alarm,
    output logic               warn_lamp,
    output logic               chime_done,
    output logic [STATE_W-1:0] state_o
);

    localparam int unsigned CNT_W  = $clog2(max3(DELAY_CYC, BEEP_ON_CYC, BEEP_OFF_CYC) + 1);
    localparam int unsigned BEEP_W = $clog2(MAX_BEEPS + 1);

    logic d_db, k_db, s_db, b_db;
    logic cond_c;

    belt_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_d (.clk(clk), .rst_n(rst_n), .raw(d_in), .level(d_db));
    belt_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_k (.clk(clk), .rst_n(rst_n), .raw(k_in), .level(k_db));
    belt_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_s (.clk(clk), .rst_n(rst_n), .raw(s_in), .level(s_db));
    belt_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_b (.clk(clk), .rst_n(rst_n), .raw(b_in), .level(b_db));

`ifdef BELT_PASSENGER_CHECK_EN
    logic pb_db;

    belt_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_pb (.clk(clk), .rst_n(rst_n), .raw(pb_in), .level(pb_db));

    assign cond_c = k_db & (~(d_db & b_db) | (s_db & ~pb_db));
`else
    // Seat occupancy is still conditioned but gated out of the warning.
    assign cond_c = k_db & (~(d_db & b_db) | (s_db & 1'b0));
`endif

    belt_state_e       state, state_nx;
    logic [CNT_W-1:0]  timer, timer_nx;
    logic [BEEP_W-1:0] beep_cnt, beep_nx;
    logic              chime_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            beep_cnt   <= '0;
            alarm      <= 1'b0;
            warn_lamp  <= 1'b0;
            chime_done <= 1'b0;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            beep_cnt   <= beep_nx;
            alarm      <= (state_nx == BEEP_ON);
            warn_lamp  <= (state_nx != IDLE);
            chime_done <= chime_nx;
        end
    end

    // Losing the warning condition beats any timer expiry in the same cycle.
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        beep_nx  = beep_cnt;
        chime_nx = 1'b0;
        if ((state != IDLE) && !cond_c) begin
            state_nx = IDLE;
            timer_nx = '0;
            beep_nx  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cond_c) begin
                        state_nx = GRACE;
                        timer_nx = CNT_W'(DELAY_CYC - 1);
                        beep_nx  = '0;
                    end
                end
                GRACE: begin
                    if (timer == '0) begin
                        state_nx = BEEP_ON;
                        timer_nx = CNT_W'(BEEP_ON_CYC - 1);
                        beep_nx  = '0;
                    end else begin
                        timer_nx = timer - CNT_W'(1);
                    end
                end
                BEEP_ON: begin
                    if (timer == '0) begin
                        state_nx = BEEP_OFF;
                        timer_nx = CNT_W'(BEEP_OFF_CYC - 1);
                        if (beep_cnt != '1) begin
                            beep_nx = beep_cnt + BEEP_W'(1);
                        end
                    end else begin
                        timer_nx = timer - CNT_W'(1);
                    end
                end
                BEEP_OFF: begin
                    if (timer == '0) begin
                        if (beep_cnt >= BEEP_W'(MAX_BEEPS)) begin
                            state_nx = LAMP_ONLY;
                            chime_nx = 1'b1;
                        end else begin
                            state_nx = BEEP_ON;
                            timer_nx = CNT_W'(BEEP_ON_CYC - 1);
                        end
                    end else begin
                        timer_nx = timer - CNT_W'(1);
                    end
                end
                LAMP_ONLY: begin
                    state_nx = LAMP_ONLY;
                end
                default: begin
                    state_nx = IDLE;
                    timer_nx = '0;
                    beep_nx  = '0;
                end
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_belt_warning_ctrl.sv
// Scoreboard bench for belt_warning_ctrl; honours BELT_PASSENGER_CHECK_EN.
module tb_belt_warning_ctrl;

    localparam int DB    = 4;
    localparam int DELAY = 10;
    localparam int ON    = 3;
    localparam int OFF   = 3;
    localparam int MAXB  = 2;

    typedef struct packed {
        logic [2:0] st;
        logic       alarm;
        logic       lamp;
        logic       chime;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       d_in, k_in, s_in, b_in, pb_in;
    logic       alarm, warn_lamp, chime_done;
    logic [2:0] state_o;

    int checks   = 0;
    int failures = 0;

    belt_warning_ctrl #(
        .DEBOUNCE_CYC(DB), .DELAY_CYC(DELAY), .BEEP_ON_CYC(ON),
        .BEEP_OFF_CYC(OFF), .MAX_BEEPS(MAXB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .d_in(d_in), .k_in(k_in), .s_in(s_in), .b_in(b_in),
`ifdef BELT_PASSENGER_CHECK_EN
        .pb_in(pb_in),
`endif
        .alarm(alarm), .warn_lamp(warn_lamp), .chime_done(chime_done),
        .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw sample windows for debouncing, elapsed-time arithmetic for the sequence.
    exp_t           exp_q[$];
    logic [DB+1:0]  hist [5];
    logic           dbv  [5];
    int             t_cond;

    function automatic exp_t expect_of(int t);
        exp_t e;
        int p, q, per;
        e = '0;
        if (t == 0) return e;
        p = t - 1;
        per = ON + OFF;
        if (p < DELAY) begin
            e.st = 3'd1;
        end else begin
            q = p - DELAY;
            if (q / per < MAXB) begin
                e.st = (q % per < ON) ? 3'd2 : 3'd3;
            end else begin
                e.st    = 3'd4;
                e.chime = (q == MAXB * per);
            end
        end
        e.alarm = (e.st == 3'd2);
        e.lamp  = 1'b1;
        return e;
    endfunction

    always @(posedge clk) begin
        logic cond;
        logic raw [5];
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                hist[i] = '0;
                dbv[i]  = 1'b0;
            end
            t_cond = 0;
            exp_q.push_back('0);
        end else begin
            raw[0] = d_in; raw[1] = k_in; raw[2] = s_in; raw[3] = b_in; raw[4] = pb_in;
`ifdef BELT_PASSENGER_CHECK_EN
            cond = dbv[1] & (~(dbv[0] & dbv[3]) | (dbv[2] & ~dbv[4]));
`else
            cond = dbv[1] & ~(dbv[0] & dbv[3]);
`endif
            t_cond = cond ? t_cond + 1 : 0;
            exp_q.push_back(expect_of(t_cond));
            for (int i = 0; i < 5; i++) begin
                hist[i] = {hist[i][DB:0], raw[i]};
                if (hist[i][DB+1:2] == {DB{~dbv[i]}}) dbv[i] = ~dbv[i];
            end
        end
    end

    // Monitor: compare every presented output cycle against the queued expectation.
    always @(negedge clk) begin
        exp_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state_o, alarm, warn_lamp, chime_done};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL cycle_outputs t=%0t got st=%0d a=%b l=%b c=%b want st=%0d a=%b l=%b c=%b",
                         $time, a.st, a.alarm, a.lamp, a.chime, e.st, e.alarm, e.lamp, e.chime);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_alarm(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (alarm === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s alarm never rose within 200 cycles, got %b want 1", name, alarm);
        end
        #1;
    endtask

    task automatic set_in(input logic k, input logic d, input logic b, input logic s, input logic pb);
        k_in = k; d_in = d; b_in = b; s_in = s; pb_in = pb;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0);
        #1;
        checks++;
        if ({alarm, warn_lamp, chime_done, state_o} !== 6'b0) begin
            failures++;
            $display("FAIL reset_state got %b want 000000", {alarm, warn_lamp, chime_done, state_o});
        end
        step(3);
        rst_n = 1'b1;
        step(2);

        // Full sequence with belt unlatched.
        set_in(1, 1, 0, 0, 0);
        step(60);

        // Belt latched: no warning for a long stretch.
        set_in(1, 1, 1, 0, 0);
        step(200);

        // Belt latched mid-beep aborts the sequence.
        set_in(1, 1, 0, 0, 0);
        wait_alarm("abort_entry");
        set_in(1, 1, 1, 0, 0);
        step(20);

        // Bouncing key never passes the debouncer.
        set_in(0, 1, 0, 0, 0);
        step(10);
        for (int i = 0; i < 20; i++) begin
            k_in = ~k_in;
            step(2);
        end
        k_in = 1'b0;
        step(10);

        // Asynchronous reset during a beep, then a full restart.
        set_in(1, 1, 0, 0, 0);
        wait_alarm("reset_entry");
        rst_n = 1'b0;
        #1;
        checks++;
        if (alarm !== 1'b0 || warn_lamp !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got alarm=%b lamp=%b want 0 0", alarm, warn_lamp);
        end
        step(3);
        rst_n = 1'b1;
        step(60);

        // Passenger occupied with belt open.
        set_in(1, 1, 1, 1, 0);
        step(60);
        pb_in = 1'b1;
        step(20);

        // Randomized input activity with random hold times.
        for (int i = 0; i < 120; i++) begin
            int sel;
            sel = int'($urandom_range(0, 4));
            case (sel)
                0: d_in  = ~d_in;
                1: k_in  = ~k_in;
                2: s_in  = ~s_in;
                3: b_in  = ~b_in;
                default: pb_in = ~pb_in;
            endcase
            step(int'($urandom_range(1, 30)));
        end

        step(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
